// File: rtl/bram_selftest_seq.sv
// Self-test sequencer for a true dual-port BRAM: write pattern, read back, compare.
// Define BRAM_SELFTEST_INV_EN to add a second pass with the inverted pattern.
module bram_selftest_seq #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    RD_LAT     = 1,
    parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  we_a,
    output logic                  we_b,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam int HALF = 1 << (ADDR_WIDTH - 1);
    localparam int CW   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(HALF - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_D = ADDR_WIDTH'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  inv
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_WIDTH && i < ADDR_WIDTH; i++) begin
            w[i] = a[i];
        end
        w = w ^ SEED;
        return inv ? ~w : w;
    endfunction

    // Step k covers the even/odd address pair {k, port}.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [ADDR_WIDTH-1:0] k,
        input logic                  port
    );
        return ADDR_WIDTH'({k, port});
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic                  inv_q, inv_d;

    logic                  pv_q [RD_LAT];
    logic                  pv_d [RD_LAT];
    logic [ADDR_WIDTH-1:0] pk_q [RD_LAT];
    logic [ADDR_WIDTH-1:0] pk_d [RD_LAT];
    logic                  pi_q [RD_LAT];
    logic                  pi_d [RD_LAT];

    logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [CW-1:0]         err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic [ADDR_WIDTH-1:0] cmp_k;
    logic                  cmp_inv;
    logic                  mis_a, mis_b;
    logic [CW:0]           err_sum;

    // Expected-value pipe, aligned with the BRAM read latency.
    always_comb begin
        pv_d[0] = (state_q == S_READ);
        pk_d[0] = k_q;
        pi_d[0] = inv_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pk_d[i] = pk_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
    end

    always_comb begin
        cmp_k   = pk_q[RD_LAT-1];
        cmp_inv = pi_q[RD_LAT-1];
        mis_a   = pv_q[RD_LAT-1]
                  && (q_a != pattern(addr_of(cmp_k, 1'b0), cmp_inv));
        mis_b   = pv_q[RD_LAT-1]
                  && (q_b != pattern(addr_of(cmp_k, 1'b1), cmp_inv));
        err_sum = {1'b0, err_count_q}
                  + (CW+1)'(mis_a) + (CW+1)'(mis_b);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        inv_d       = inv_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;

        if (mis_a || mis_b) begin
            err_count_d = err_sum[CW] ? '1 : err_sum[CW-1:0];
            if (err_count_q == '0) begin
                err_addr_d = mis_a ? addr_of(cmp_k, 1'b0)
                                   : addr_of(cmp_k, 1'b1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    k_d         = '0;
                    inv_d       = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_addr_d  = '0;
                end
            end
            S_WRITE: begin
                if (k_q == LAST_K) begin
                    state_d = S_READ;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_READ: begin
                if (k_q == LAST_K) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (k_q == LAST_D) begin
                    k_d = '0;
`ifdef BRAM_SELFTEST_INV_EN
                    if (!inv_q) begin
                        state_d = S_WRITE;
                        inv_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) begin
            pass_d = (err_count_d == '0);
        end
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        we_d     = (state_d == S_WRITE);
        busy_d   = (state_d == S_WRITE) || (state_d == S_READ)
                   || (state_d == S_DRAIN);
        done_d   = (state_d == S_DONE);
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = '0;
        data_b_d = '0;
        if (state_d == S_WRITE || state_d == S_READ) begin
            addr_a_d = addr_of(k_d, 1'b0);
            addr_b_d = addr_of(k_d, 1'b1);
        end
        if (we_d) begin
            data_a_d = pattern(addr_of(k_d, 1'b0), inv_d);
            data_b_d = pattern(addr_of(k_d, 1'b1), inv_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            inv_q       <= 1'b0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pk_q[i] <= '0;
                pi_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            inv_q       <= inv_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= pv_d[i];
                pk_q[i] <= pk_d[i];
                pi_q[i] <= pi_d[i];
            end
        end
    end

    assign data_a    = data_a_q;
    assign data_b    = data_b_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign we_a      = we_q;
    assign we_b      = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bram_selftest_seq.sv
// Bench for bram_selftest_seq: two DUT configurations, each with a faultable BRAM model.
module tb_bram_selftest_seq;

`ifdef BRAM_SELFTEST_INV_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Fault controls shared by both BRAM models
    int          flip_addr  = -1;
    logic [15:0] flip_mask  = '0;
    bit          zero_b     = 1'b0;
    int          stuck_addr = -1;
    logic [15:0] stuck_mask = '0;

    function automatic logic [15:0] corrupt(input int a, input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (a == flip_addr) r = r ^ flip_mask;
        if (a == stuck_addr) r = r & ~stuck_mask;
        if (zero_b && (a % 2 == 1)) r = '0;
        return r;
    endfunction

    // DUT 0: ADDR_WIDTH=4, RD_LAT=1, SEED=0
    logic        s0 = 1'b0;
    logic [15:0] qa0, qb0, da0, db0;
    logic [3:0]  aa0, ab0, ea0;
    logic [4:0]  ec0;
    logic        wea0, web0, busy0, done0, pass0;
    logic [15:0] mem0 [16];

    bram_selftest_seq #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LAT(1), .SEED(16'h0000)
    ) dut0 (
        .clk(clk), .reset(reset), .start(s0), .q_a(qa0), .q_b(qb0),
        .data_a(da0), .data_b(db0), .addr_a(aa0), .addr_b(ab0),
        .we_a(wea0), .we_b(web0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(ec0), .err_addr(ea0)
    );

    always @(posedge clk) begin
        if (wea0) mem0[aa0] <= da0;
        if (web0) mem0[ab0] <= db0;
        qa0 <= corrupt(int'(aa0), mem0[aa0]);
        qb0 <= corrupt(int'(ab0), mem0[ab0]);
    end

    // DUT 1: ADDR_WIDTH=3, RD_LAT=2, SEED=FFFF
    logic        s1 = 1'b0;
    logic [15:0] qa1, qb1, qa1_p, qb1_p, da1, db1;
    logic [2:0]  aa1, ab1, ea1;
    logic [3:0]  ec1;
    logic        wea1, web1, busy1, done1, pass1;
    logic [15:0] mem1 [8];

    bram_selftest_seq #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .RD_LAT(2), .SEED(16'hFFFF)
    ) dut1 (
        .clk(clk), .reset(reset), .start(s1), .q_a(qa1), .q_b(qb1),
        .data_a(da1), .data_b(db1), .addr_a(aa1), .addr_b(ab1),
        .we_a(wea1), .we_b(web1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ec1), .err_addr(ea1)
    );

    always @(posedge clk) begin
        if (wea1) mem1[aa1] <= da1;
        if (web1) mem1[ab1] <= db1;
        qa1_p <= corrupt(int'(aa1), mem1[aa1]);
        qb1_p <= corrupt(int'(ab1), mem1[ab1]);
        qa1   <= qa1_p;
        qb1   <= qb1_p;
    end

    // Probes captured by run() in cycles 1 and 2 after the start is sampled
    logic        c1_we, c1_busy;
    int          c1_aa, c1_ab;
    logic [15:0] c2_db;

    task automatic clear_faults();
        flip_addr  = -1;
        flip_mask  = '0;
        zero_b     = 1'b0;
        stuck_addr = -1;
        stuck_mask = '0;
    endtask

    // Reference: every word holds its pattern (inverted on pass 2); count reads the fault model alters.
    task automatic model(input int aw, input int rl, input logic [15:0] seed,
                         output int cnt, output int first, output int dcyc);
        int depth;
        int raw;
        logic [15:0] v;
        depth = 1 << aw;
        raw   = 0;
        first = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < depth; a++) begin
                v = 16'(a) ^ seed;
                if (p == 1) v = ~v;
                if (corrupt(a, v) !== v) begin
                    if (raw == 0) first = a;
                    raw++;
                end
            end
        end
        cnt  = (raw > 2 * depth - 1) ? 2 * depth - 1 : raw;
        dcyc = NPASS * (depth + rl) + 1;
    endtask

    // Start one run; cyc = cycle of done (-1 on timeout)
    task automatic run(input int which, input int pulse_at, output int cyc,
                       output int ec, output int ea, output logic ps);
        int n;
        logic d;
        cyc = -1;
        ec  = -1;
        ea  = -1;
        ps  = 1'bx;
        @(posedge clk); #1;
        if (which == 0) s0 = 1'b1; else s1 = 1'b1;
        @(posedge clk); #1;
        s0 = 1'b0;
        s1 = 1'b0;
        n  = 1;
        while (n < 300 && cyc < 0) begin
            if (n == 1) begin
                c1_we   = (which == 0) ? (wea0 & web0) : (wea1 & web1);
                c1_busy = (which == 0) ? busy0 : busy1;
                c1_aa   = (which == 0) ? int'(aa0) : int'(aa1);
                c1_ab   = (which == 0) ? int'(ab0) : int'(ab1);
            end
            if (n == 2) c2_db = (which == 0) ? db0 : db1;
            if (n == pulse_at) begin
                if (which == 0) s0 = 1'b1; else s1 = 1'b1;
            end else begin
                s0 = 1'b0;
                s1 = 1'b0;
            end
            d = (which == 0) ? done0 : done1;
            if (d) begin
                cyc = n;
                ec  = (which == 0) ? int'(ec0) : int'(ec1);
                ea  = (which == 0) ? int'(ea0) : int'(ea1);
                ps  = (which == 0) ? pass0 : pass1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        s0 = 1'b0;
        s1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({wea0, web0, busy0, done0, pass0, ec0, ea0, aa0, ab0, da0, db0} !== '0) begin
            fails++;
            $display("FAIL reset_outputs dut0: got %h want 0",
                     {wea0, web0, busy0, done0, pass0, ec0, ea0, aa0, ab0, da0, db0});
        end
        tests++;
        if ({wea1, busy1, done1, pass1, ec1, ea1, db1} !== '0) begin
            fails++;
            $display("FAIL reset_outputs dut1: got %h want 0",
                     {wea1, busy1, done1, pass1, ec1, ea1, db1});
        end
        reset = 1'b0;
    endtask

    task automatic check_run(input string name, input int which, input int pulse_at);
        int cyc, ec, ea, mc, mf, md;
        logic ps;
        if (which == 0) model(4, 1, 16'h0000, mc, mf, md);
        else            model(3, 2, 16'hFFFF, mc, mf, md);
        run(which, pulse_at, cyc, ec, ea, ps);
        tests++;
        if (cyc !== md) begin
            fails++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, md);
        end
        tests++;
        if (ec !== mc) begin
            fails++;
            $display("FAIL %s err_count: got %0d want %0d", name, ec, mc);
        end
        tests++;
        if (ea !== mf) begin
            fails++;
            $display("FAIL %s err_addr: got %0d want %0d", name, ea, mf);
        end
        tests++;
        if (ps !== (mc == 0)) begin
            fails++;
            $display("FAIL %s pass: got %b want %b", name, ps, (mc == 0));
        end
    endtask

    task automatic test_ideal();
        logic [15:0] w5;
        clear_faults();
        check_run("ideal", 0, 0);
        tests++;
        if ({c1_we, c1_busy} !== 2'b11 || c1_aa != 0 || c1_ab != 1) begin
            fails++;
            $display("FAIL first_write: got we/busy=%b%b a=%0d b=%0d want 11 0 1",
                     c1_we, c1_busy, c1_aa, c1_ab);
        end
        w5 = (NPASS == 2) ? 16'hFFFA : 16'h0005;
        tests++;
        if (mem0[5] !== w5) begin
            fails++;
            $display("FAIL word5: got %h want %h", mem0[5], w5);
        end
        @(posedge clk); #1;
        tests++;
        if ({done0, busy0, pass0} !== 3'b001) begin
            fails++;
            $display("FAIL after_done: got done/busy/pass=%b want 001", {done0, busy0, pass0});
        end
    endtask

    task automatic test_flip();
        clear_faults();
        flip_addr = 5;
        flip_mask = 16'h0001;
        check_run("flip5", 0, 0);
    endtask

    task automatic test_zero_b();
        clear_faults();
        zero_b = 1'b1;
        check_run("zero_b", 0, 0);
    endtask

    task automatic test_seed();
        clear_faults();
        check_run("seed", 1, 0);
        tests++;
        if (c2_db !== (16'h0003 ^ 16'hFFFF)) begin
            fails++;
            $display("FAIL seed_data_b: got %h want %h", c2_db, 16'h0003 ^ 16'hFFFF);
        end
    endtask

    task automatic test_start_ignored();
        clear_faults();
        check_run("start_in_read", 0, 10);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy0 !== 1'b0) begin
            fails++;
            $display("FAIL no_requeue: got busy=%b want 0", busy0);
        end
    endtask

    task automatic test_reset_midrun();
        clear_faults();
        zero_b = 1'b1;
        @(posedge clk); #1;
        s0 = 1'b1;
        @(posedge clk); #1;
        s0 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        tests++;
        if (ec0 === '0) begin
            fails++;
            $display("FAIL midrun_errors: got err_count=%0d want nonzero", ec0);
        end
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({wea0, web0, busy0, done0, ec0} !== '0) begin
            fails++;
            $display("FAIL async_reset: got %b want 0", {wea0, web0, busy0, done0, ec0});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_faults();
        check_run("after_reset", 0, 0);
        tests++;
        if (c1_we !== 1'b1 || c1_aa != 0 || c1_ab != 1) begin
            fails++;
            $display("FAIL restart_addr: got we=%b a=%0d b=%0d want 1 0 1",
                     c1_we, c1_aa, c1_ab);
        end
    endtask

    task automatic test_stuck();
        clear_faults();
        stuck_addr = 2;
        stuck_mask = 16'h0001;
        check_run("stuck_bit", 0, 0);
    endtask

    task automatic test_random();
        int which;
        for (int it = 0; it < 6; it++) begin
            which = it % 2;
            clear_faults();
            flip_addr = $urandom_range(0, (which == 0) ? 15 : 7);
            flip_mask = 16'($urandom);
            zero_b    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                stuck_addr = $urandom_range(0, 7);
                stuck_mask = 16'(1) << $urandom_range(0, 15);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            check_run("random", which, 0);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_flip();
        test_zero_b();
        test_seed();
        test_start_ignored();
        test_reset_midrun();
        test_stuck();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
